// File: rtl/sudoku_pkg.sv
// Shared constants, FSM state encoding and board indexing for the Sudoku move checker.
// Cell (i,j) lives at board bit offset 4*cell_index(i,j).
package sudoku_pkg;

  localparam int GRID_N    = 9;
  localparam int CELL_W    = 4;
  localparam int NUM_CELLS = GRID_N * GRID_N;
  localparam int BOARD_W   = NUM_CELLS * CELL_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_BOX,
    ST_DONE
  } mc_state_t;

  function automatic logic [6:0] cell_index(input logic [3:0] i, input logic [3:0] j);
    return 7'(i) * 7'd9 + 7'(j);
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Combinational address generator: maps (scan state, step k, target) to the examined cell.
// Zero latency; returns (0,0) outside the scan states.
module scan_addr_gen
  import sudoku_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] k,
  input  logic [3:0] pi,
  input  logic [3:0] pj,
  output logic [3:0] ei,
  output logic [3:0] ej
);

  logic [3:0] bi;
  logic [3:0] bj;
  logic [3:0] k_div3;
  logic [3:0] k_mod3;

  always_comb begin
    bi     = (pi / 4'd3) * 4'd3;
    bj     = (pj / 4'd3) * 4'd3;
    k_div3 = k / 4'd3;
    k_mod3 = k - k_div3 * 4'd3;
    ei     = 4'd0;
    ej     = 4'd0;
    case (state)
      ST_ROW: begin
        ei = pi;
        ej = k;
      end
      ST_COL: begin
        ei = k;
        ej = pj;
      end
      ST_BOX: begin
        ei = bi + k_div3;
        ej = bj + k_mod3;
      end
      default: begin
        ei = 4'd0;
        ej = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/move_checker.sv
// Sudoku placement legality checker: 27-step row/col/box scan, done 28 cycles after start
// (s+2 on first conflict at step s when MOVE_CHECKER_EARLY_EXIT_EN is defined); start ignored unless IDLE.
module move_checker
  import sudoku_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           pos_i,
  input  logic [3:0]           pos_j,
  input  logic [CELL_W-1:0]    value,
  input  logic [BOARD_W-1:0]   board,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic                 range_error,
  output logic [3:0]           conflict_i,
  output logic [3:0]           conflict_j
);

  localparam logic [3:0] LAST_K = 4'(GRID_N - 1);

  mc_state_t   state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  pi_q, pi_d;
  logic [3:0]  pj_q, pj_d;
  logic [3:0]  val_q, val_d;
  logic        conflict_q, conflict_d;
  logic        valid_q, valid_d;
  logic        range_error_q, range_error_d;
  logic [3:0]  ci_q, ci_d;
  logic [3:0]  cj_q, cj_d;

  logic [3:0]  ei;
  logic [3:0]  ej;
  logic [8:0]  cell_off;
  logic [3:0]  cell_val;
  logic        scanning;
  logic        hit;

  scan_addr_gen u_addr (
    .state (state_q),
    .k     (k_q),
    .pi    (pi_q),
    .pj    (pj_q),
    .ei    (ei),
    .ej    (ej)
  );

  // The board is read live; the caller keeps it stable while busy.
  always_comb begin
    cell_off = {cell_index(ei, ej), 2'b00};
    cell_val = board[cell_off +: CELL_W];
    scanning = (state_q == ST_ROW) || (state_q == ST_COL) || (state_q == ST_BOX);
    hit      = scanning && (cell_val == val_q) && !((ei == pi_q) && (ej == pj_q));
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    pi_d          = pi_q;
    pj_d          = pj_q;
    val_d         = val_q;
    conflict_d    = conflict_q;
    valid_d       = valid_q;
    range_error_d = range_error_q;
    ci_d          = ci_q;
    cj_d          = cj_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pi_d          = pos_i;
          pj_d          = pos_j;
          val_d         = value;
          k_d           = 4'd0;
          conflict_d    = 1'b0;
          valid_d       = 1'b0;
          range_error_d = 1'b0;
          ci_d          = 4'd0;
          cj_d          = 4'd0;
          if ((pos_i > LAST_K) || (pos_j > LAST_K) || (value > 4'(GRID_N))) begin
            range_error_d = 1'b1;
            state_d       = ST_DONE;
          end else if (value == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ROW;
          end
        end
      end
      ST_ROW, ST_COL, ST_BOX: begin
        if (hit && !conflict_q) begin
          conflict_d = 1'b1;
          ci_d       = ei;
          cj_d       = ej;
        end
        if (k_q == LAST_K) begin
          k_d = 4'd0;
          case (state_q)
            ST_ROW:  state_d = ST_COL;
            ST_COL:  state_d = ST_BOX;
            default: state_d = ST_DONE;
          endcase
        end else begin
          k_d = k_q + 4'd1;
        end
`ifdef MOVE_CHECKER_EARLY_EXIT_EN
        if (hit) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Result is registered on entry to DONE so it is stable during the done pulse.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      valid_d = !conflict_d && !range_error_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      k_q           <= 4'd0;
      pi_q          <= 4'd0;
      pj_q          <= 4'd0;
      val_q         <= 4'd0;
      conflict_q    <= 1'b0;
      valid_q       <= 1'b0;
      range_error_q <= 1'b0;
      ci_q          <= 4'd0;
      cj_q          <= 4'd0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      pi_q          <= pi_d;
      pj_q          <= pj_d;
      val_q         <= val_d;
      conflict_q    <= conflict_d;
      valid_q       <= valid_d;
      range_error_q <= range_error_d;
      ci_q          <= ci_d;
      cj_q          <= cj_d;
    end
  end

  assign busy        = scanning;
  assign done        = (state_q == ST_DONE);
  assign valid       = valid_q;
  assign range_error = range_error_q;
  assign conflict_i  = ci_q;
  assign conflict_j  = cj_q;

endmodule
